// File: rtl/arm_boot_ctrl.sv
// arm_boot_ctrl: boot/run sequencer for the ARM core and memory port 2.
// Loads a program word stream into memory while the core is held in reset,
// releases the core after a short hold, passes the port through while it
// runs, then freezes the core and hands the port to a debug read address.
//
// Handshake: a load word transfers on a rising edge where load_valid and
// load_ready are both high; load_ready depends only on state, never on
// load_valid, and load_data/load_last are only meaningful while load_valid.
module arm_boot_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned RUN_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [31:0] core_mem_addr,
    input  logic [31:0] core_mem_data_in,
    input  logic        core_mem_write_en,
    input  logic        core_halted,
    input  logic [31:0] dbg_addr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_write_en,
    output logic        core_rst,
    output logic        done,
    output logic        halt_seen,
    output logic        timeout,
    output logic        error,
    output logic [15:0] word_count,
    output logic [31:0] cycle_count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0] TIMEOUT_C = 32'(RUN_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] word_count_q, word_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        done_q, done_d;
    logic        halt_seen_q, halt_seen_d;
    logic        timeout_q, timeout_d;
    logic        error_q, error_d;

    // State register and all sticky flags/counters; async reset to boot defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            wr_addr_q     <= 32'd0;
            wr_data_q     <= 32'd0;
            wr_en_q       <= 1'b0;
            hold_cnt_q    <= 32'd0;
            word_count_q  <= 16'd0;
            cycle_count_q <= 32'd0;
            done_q        <= 1'b0;
            halt_seen_q   <= 1'b0;
            timeout_q     <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            hold_cnt_q    <= hold_cnt_d;
            word_count_q  <= word_count_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            halt_seen_q   <= halt_seen_d;
            timeout_q     <= timeout_d;
            error_q       <= error_d;
        end
    end

    // Next-state logic: load writes are registered, run-phase events set sticky flags.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_en_d       = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        word_count_d  = word_count_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        halt_seen_d   = halt_seen_q;
        timeout_d     = timeout_q;
        error_d       = error_q;
        case (state_q)
            S_INIT: state_d = S_LOAD;
            S_LOAD: begin
                if (load_valid) begin
                    if (32'(word_count_q) < MAX_W) begin
                        wr_addr_d    = BASE_ADDR + 32'({word_count_q, 2'b00});
                        wr_data_d    = load_data;
                        wr_en_d      = 1'b1;
                        word_count_d = word_count_q + 16'd1;
                        if (load_last) begin
                            state_d    = S_HOLD;
                            hold_cnt_d = 32'd0;
                        end
                    end else begin
                        // Overflowing word is dropped, never written.
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                // Halt has priority over a simultaneous timeout.
                if (core_halted) begin
                    done_d      = 1'b1;
                    halt_seen_d = 1'b1;
                    state_d     = S_DONE;
                end else if ((TIMEOUT_C != 32'd0) && (cycle_count_q == TIMEOUT_C - 32'd1)) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: ;
        endcase
    end

    // Memory port mux: registered load writes, core pass-through in RUN, debug reads when finished.
    always_comb begin
        mem_addr     = wr_addr_q;
        mem_data_in  = wr_data_q;
        mem_write_en = wr_en_q;
        case (state_q)
            S_RUN: begin
                mem_addr     = core_mem_addr;
                mem_data_in  = core_mem_data_in;
                mem_write_en = core_mem_write_en;
            end
            S_DONE, S_ERR: begin
                mem_addr     = dbg_addr;
                mem_data_in  = 32'd0;
                mem_write_en = 1'b0;
            end
            default: ;
        endcase
    end

    assign load_ready  = (state_q == S_LOAD);
    assign core_rst    = (state_q != S_RUN);
    assign done        = done_q;
    assign halt_seen   = halt_seen_q;
    assign timeout     = timeout_q;
    assign error       = error_q;
    assign word_count  = word_count_q;
    assign cycle_count = cycle_count_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/arm_boot_ctrl.md
# arm_boot_ctrl

Boot/run sequencer for the ARM core and the data port (port 2) of the ARM memory. It holds the core in reset and accepts a program as a stream of 32-bit words, writing them to consecutive word addresses. It then releases the core and passes the memory port through to it. When the core halts or a cycle budget expires, it freezes the core and hands the port to a debug read address for result dumping.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, 1024: maximum program length in words (≥1).
- `RST_HOLD`, 4: cycles `core_rst` stays high after the final load write (≥1).
- `RUN_TIMEOUT`, 0: run-cycle budget; 0 disables the timeout.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load_valid` input 1: load word valid.
- `load_data` input 32: program word.
- `load_last` input 1: marks the final program word; qualified by `load_valid`.
- `load_ready` output 1: loader accepts a word this cycle.
- `core_mem_addr` input 32: core data address.
- `core_mem_data_in` input 32: core write data.
- `core_mem_write_en` input 1: core write enable.
- `core_halted` input 1: core halt indication.
- `dbg_addr` input 32: read address used in the DONE state.
- `mem_addr` output 32: to memory `addr2`.
- `mem_data_in` output 32: to memory `data_in2`.
- `mem_write_en` output 1: to memory `we[1]`.
- `core_rst` output 1: reset to the core.
- `done` output 1: run finished, sticky.
- `halt_seen` output 1: finish caused by `core_halted`.
- `timeout` output 1: finish caused by `RUN_TIMEOUT`.
- `error` output 1: program overflowed `MAX_WORDS`.
- `word_count` output 16: words written.
- `cycle_count` output 32: cycles spent in RUN.

## Operation
- **States:** INIT, LOAD, HOLD, RUN, DONE, ERR.
- **Reset values (asynchronous):** state INIT, `load_ready` 0, `mem_addr` 0, `mem_data_in` 0, `mem_write_en` 0, `core_rst` 1. All flags 0, both counters 0.
- **INIT:** advances unconditionally to LOAD on the next edge.
- **LOAD:**
  - `load_ready` = 1.
  - On handshake (`load_valid & load_ready`) with `word_count < MAX_WORDS`, register the write: `mem_addr` = `BASE_ADDR + 4*word_count` (mod 2^32), `mem_data_in` = `load_data`, `mem_write_en` = 1. Then `word_count++`.
  - With no handshake, `mem_write_en` = 0.
  - If the accepted word has `load_last` = 1, go to HOLD.
  - If a handshake occurs with `word_count == MAX_WORDS`, the word is not written; set `error`, go to ERR.
- **HOLD:**
  - `load_ready` = 0, `mem_write_en` = 0, `core_rst` = 1.
  - Counts `RST_HOLD` cycles, then goes to RUN.
- **RUN:**
  - `core_rst` = 0.
  - `mem_addr`, `mem_data_in` and `mem_write_en` are combinational pass-through of the `core_mem_*` inputs.
  - `cycle_count++` every cycle (saturates at 2^32−1).
  - If `core_halted`, set `done` and `halt_seen`, go to DONE.
  - Otherwise, if `RUN_TIMEOUT` ≠ 0 and `cycle_count == RUN_TIMEOUT−1`, set `done` and `timeout`, go to DONE.
  - Halt and timeout in the same cycle: halt wins; `timeout` stays 0.
- **DONE:**
  - `core_rst` = 1.
  - `mem_addr` = `dbg_addr` (combinational), `mem_write_en` = 0, `mem_data_in` = 0.
  - Terminal until `rst`.
- **ERR:** same outputs as DONE, except `done` = 0 and `error` = 1. Terminal until `rst`.
- **Ignored inputs:** `load_valid` outside LOAD is ignored. `load_last` without `load_valid` is ignored. A `core_halted` pulse before RUN is ignored.
- **Reset mid-operation:** all state and outputs return to reset values immediately. Partially loaded memory contents are not cleared.

## Timing
- **Load write latency:** a handshake at edge N presents the write on the memory port during cycle N..N+1. Memory captures it at edge N+1.
- **Load throughput:** one word per cycle.
- **Core release:** the final word is accepted at edge N; HOLD is entered at edge N. `core_rst` falls at edge N+`RST_HOLD`.
- **Run pass-through:** zero latency for core port signals.
- **Finish:** `done`, `halt_seen` and `timeout` rise at the edge after the qualifying cycle. `core_rst` rises at that same edge.
- **Overflow:** `error` rises at the edge of the offending handshake.

## Test plan
- **Load and release:** reset, stream 3 words 0xE3A00001, 0xE2800002, 0xEAFFFFFE, with last on the third. Expect writes at addresses 0, 4, 8 on consecutive cycles and `word_count` = 3. `core_rst` falls exactly `RST_HOLD` = 4 cycles after the last accept.
- **Run pass-through:** in RUN, drive `core_mem_addr` = 0x40, `core_mem_data_in` = 0x1234, `core_mem_write_en` = 1. Expect `mem_*` equal to those values in the same cycle.
- **Halt:** assert `core_halted` on the 10th RUN cycle. Expect `done` = 1, `halt_seen` = 1, `cycle_count` = 10, `core_rst` = 1. Then drive `dbg_addr` = 8 and expect `mem_addr` = 8 with writes disabled.
- **Timeout vs halt:** with `RUN_TIMEOUT` = 5 and no halt, expect `timeout` = 1 and `cycle_count` = 5. Rerun with `core_halted` asserted on cycle 5; expect `halt_seen` = 1, `timeout` = 0.
- **Overflow:** with `MAX_WORDS` = 2, stream 3 words without last. Expect 2 writes, the third not written, `error` = 1, and `core_rst` held at 1.
- **Mid-load reset:** assert `rst` after 2 words. Expect `core_rst` = 1 and `load_ready` = 0 immediately; after release, the next load restarts at `BASE_ADDR`.
